alu_flag_branch_unit: RTL and testbench
=======================================

// Module: alu_flag_branch_unit
// PURPOSE
//  Consumer end of the ALU compare-flag interface (Gr = A>B unsigned, E = A==B).
//  Holds the processor flag register, accepts conditional-branch requests from decode,
//  evaluates the condition against the current flags and issues a one-cycle PC-load.
//  Sits between the ALU compare path and the program-counter block of the 8-bit core.
// PARAMETERS
//  PC_W    8   width of branch target / PC-load value
//  CNT_W   8   width of taken-branch statistics counter (wraps)
// PORTS
//  clk          in   1      single clock, rising edge
//  rst_n        in   1      asynchronous, active-low reset
//  flg_valid    in   1      ALU compare result valid this cycle
//  flg_gr       in   1      ALU greater flag (A>B)
//  flg_e        in   1      ALU equal flag (A==B)
//  br_valid     in   1      branch request valid
//  br_cond      in   3      condition code (see BEHAVIOUR)
//  br_target    in   PC_W   branch target address
//  br_ready     out  1      unit can accept a request this cycle
//  br_done      out  1      pulse: request resolved (taken or not)
//  pc_load      out  1      pulse: PC must load pc_target (br_done & taken)
//  pc_target    out  PC_W   target of resolved request; holds until next resolve
//  flags_q      out  2      registered {gr,e}
//  flg_seen     out  1      at least one flag update since reset
//  taken_cnt    out  CNT_W  count of taken branches, wraps at 2^CNT_W
// BEHAVIOUR
//  Reset (async, rst_n=0): all outputs 0, state IDLE, pending request dropped.
//  Flag register: on flg_valid, flags_q <= {flg_gr & ~flg_e, flg_e} (E dominates
//   illegal gr=e=1), flg_seen <= 1. Always accepted, every cycle, any state.
//  Cond codes: 000 ALWAYS, 001 EQ(e), 010 NE(~e), 011 GT(gr), 100 LT(~gr&~e),
//   101 GE(gr|e), 110 LE(~gr), 111 NEVER. ALWAYS/NEVER are flag-independent.
//  Handshake: accept when br_valid & br_ready; cond/target latched on accept.
//   br_ready=1 only in IDLE. br_valid with br_ready=0 is ignored (requester holds).
//  FSM IDLE:
//   accept, flag-independent cond             -> resolve at T+1, stay IDLE
//   accept, flag-dep, flg_valid=0, flg_seen=1 -> resolve at T+1 on flags_q, stay IDLE
//   accept, flag-dep, flg_valid=1 same cycle  -> EVAL (use new flags)
//   accept, flag-dep, flg_seen=0, flg_valid=0 -> WAIT_FLAGS
//  EVAL: evaluate latched cond on flags_q; br_done/pc_load at next edge; -> IDLE.
//  WAIT_FLAGS: br_ready=0; on flg_valid -> EVAL; otherwise stay (no timeout).
//  Latency accept->br_done: 1 cycle normal, 2 on flag collision, flg arrival+2 when waiting.
//  br_done, pc_load: registered single-cycle pulses; back-to-back accepts in IDLE
//   give back-to-back pulses. pc_target updates on every resolve (taken or not).
//  taken_cnt increments on each pc_load, wraps 0xFF->0x00.
//  Flag update in the cycle an IDLE-path request resolves does not alter that result.
// STRUCTURE
//  Package alu_flag_pkg: cond-code localparams (COND_ALWAYS..COND_NEVER),
//   state encoding (ST_IDLE, ST_EVAL, ST_WAIT_FLAGS), flag bit indices.
//  Sub-module branch_cond_eval: combinational (cond, gr, e) -> taken, plus
//   flag_dependent(cond) output; instantiated once in the FSM.
// TESTING
//  1 Reset mid-WAIT_FLAGS: drop rst_n -> all outputs 0, br_ready=1 after release.
//  2 flags gr=1,e=0 captured; br EQ tgt 0x3C -> T+1 br_done=1, pc_load=0, pc_target=0x3C.
//  3 flags e=1; br GE tgt 0x10 -> T+1 pc_load=1, pc_target=0x10, taken_cnt=1.
//  4 Collision: flags_q e=1, same cycle flg_valid gr=1 + br EQ -> br_ready=0 at T+1,
//    T+2 br_done=1, pc_load=0 (new flags used).
//  5 After reset br LT, no flags 5 cycles -> br_ready=0, no done; flg gr=0,e=0 -> done+pc_load 2 cycles later.
//  6 Illegal gr=e=1 -> flags_q=2'b01; 256 ALWAYS accepts back-to-back -> 256 pulses, taken_cnt wraps to 0.

Source files
------------

// File: rtl/alu_flag_pkg.sv
`default_nettype none
// ============================================================================
// Module : alu_flag_pkg
// Brief  : Shared encodings for the ALU flag / conditional branch unit.
// Rev    : 1.0  initial release
// ============================================================================
package alu_flag_pkg;

  localparam logic [2:0] COND_ALWAYS = 3'b000;
  localparam logic [2:0] COND_EQ     = 3'b001;
  localparam logic [2:0] COND_NE     = 3'b010;
  localparam logic [2:0] COND_GT     = 3'b011;
  localparam logic [2:0] COND_LT     = 3'b100;
  localparam logic [2:0] COND_GE     = 3'b101;
  localparam logic [2:0] COND_LE     = 3'b110;
  localparam logic [2:0] COND_NEVER  = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_EVAL       = 2'd1,
    ST_WAIT_FLAGS = 2'd2
  } state_t;

  localparam int FLAG_GR = 1;
  localparam int FLAG_E  = 0;

endpackage
`default_nettype wire

// File: rtl/branch_cond_eval.sv
`default_nettype none
// ============================================================================
// Module : branch_cond_eval
// Brief  : Combinational branch condition evaluation against {gr,e} flags.
// Rev    : 1.0  initial release
// ============================================================================
module branch_cond_eval
  import alu_flag_pkg::*;
(
  input  logic [2:0] cond,
  input  logic       gr,
  input  logic       e,
  output logic       taken,
  output logic       flag_dependent
);

  always_comb begin
    taken = 1'b0;
    case (cond)
      COND_ALWAYS: taken = 1'b1;
      COND_EQ:     taken = e;
      COND_NE:     taken = ~e;
      COND_GT:     taken = gr;
      COND_LT:     taken = ~gr & ~e;
      COND_GE:     taken = gr | e;
      COND_LE:     taken = ~gr;
      default:     taken = 1'b0;
    endcase
  end

  assign flag_dependent = (cond != COND_ALWAYS) && (cond != COND_NEVER);

endmodule
`default_nettype wire

// File: rtl/alu_flag_branch_unit.sv
`default_nettype none
// ============================================================================
// Module : alu_flag_branch_unit
// Brief  : Flag register plus conditional-branch resolver issuing PC loads.
// Rev    : 1.0  initial release
// ============================================================================
module alu_flag_branch_unit
  import alu_flag_pkg::*;
#(
  parameter int PC_W  = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flg_valid,
  input  logic             flg_gr,
  input  logic             flg_e,
  input  logic             br_valid,
  input  logic [2:0]       br_cond,
  input  logic [PC_W-1:0]  br_target,
  output logic             br_ready,
  output logic             br_done,
  output logic             pc_load,
  output logic [PC_W-1:0]  pc_target,
  output logic [1:0]       flags_q,
  output logic             flg_seen,
  output logic [CNT_W-1:0] taken_cnt
);

  state_t          r_state;
  logic [2:0]      r_cond;
  logic [PC_W-1:0] r_target;
  logic            r_ready;

  logic            w_accept;
  logic [2:0]      w_cond;
  logic            w_taken;
  logic            w_dep;
  logic            w_resolve;
  logic [PC_W-1:0] w_res_target;

  // Ready is registered so it reads 0 while reset is asserted.
  assign br_ready = r_ready;
  assign w_accept = br_valid & r_ready;
  assign w_cond   = (r_state == ST_IDLE) ? br_cond : r_cond;

  branch_cond_eval u_eval (
    .cond           (w_cond),
    .gr             (flags_q[FLAG_GR]),
    .e              (flags_q[FLAG_E]),
    .taken          (w_taken),
    .flag_dependent (w_dep)
  );

  always_comb begin
    w_resolve    = 1'b0;
    w_res_target = br_target;
    if (r_state == ST_IDLE) begin
      w_resolve = w_accept & (~w_dep | (~flg_valid & flg_seen));
    end else if (r_state == ST_EVAL) begin
      w_resolve    = 1'b1;
      w_res_target = r_target;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_cond    <= COND_ALWAYS;
      r_target  <= '0;
      r_ready   <= 1'b0;
      br_done   <= 1'b0;
      pc_load   <= 1'b0;
      pc_target <= '0;
      flags_q   <= 2'b00;
      flg_seen  <= 1'b0;
      taken_cnt <= '0;
    end else begin
      br_done <= 1'b0;
      pc_load <= 1'b0;

      // Illegal gr=e=1 collapses to equal.
      if (flg_valid) begin
        flags_q  <= {flg_gr & ~flg_e, flg_e};
        flg_seen <= 1'b1;
      end

      if (w_resolve) begin
        br_done   <= 1'b1;
        pc_load   <= w_taken;
        pc_target <= w_res_target;
        if (w_taken) taken_cnt <= taken_cnt + CNT_W'(1);
      end

      case (r_state)
        ST_IDLE: begin
          r_ready <= 1'b1;
          if (w_accept && !w_resolve) begin
            r_cond   <= br_cond;
            r_target <= br_target;
            r_ready  <= 1'b0;
            r_state  <= flg_valid ? ST_EVAL : ST_WAIT_FLAGS;
          end
        end
        ST_EVAL: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b1;
        end
        ST_WAIT_FLAGS: begin
          if (flg_valid) r_state <= ST_EVAL;
        end
        default: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_flag_branch_unit.sv
`default_nettype none
// ============================================================================
// Module : tb_alu_flag_branch_unit
// Brief  : Directed, table-driven bench for alu_flag_branch_unit.
// Rev    : 1.0  initial release
// ============================================================================
module tb_alu_flag_branch_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       flg_valid = 1'b0, flg_gr = 1'b0, flg_e = 1'b0;
  logic       br_valid = 1'b0;
  logic [2:0] br_cond = 3'b000;
  logic [7:0] br_target = 8'h00;
  logic       br_ready, br_done, pc_load, flg_seen;
  logic [7:0] pc_target, taken_cnt;
  logic [1:0] flags_q;

  int n_cmp = 0;
  int n_err = 0;

  alu_flag_branch_unit #(.PC_W(8), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .flg_valid(flg_valid), .flg_gr(flg_gr), .flg_e(flg_e),
    .br_valid(br_valid), .br_cond(br_cond), .br_target(br_target),
    .br_ready(br_ready), .br_done(br_done), .pc_load(pc_load),
    .pc_target(pc_target), .flags_q(flags_q), .flg_seen(flg_seen),
    .taken_cnt(taken_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic       fv, gr, e, bv;
    logic [2:0] cond;
    logic [7:0] tgt;
    logic       x_done, x_load;
    logic [7:0] x_tgt;
    logic [1:0] x_flags;
    logic [7:0] x_cnt;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    br_valid = 1'b0; flg_valid = 1'b0;
    rst_n = 1'b0;
    #2;
    chk("rst_ready", br_ready, 0);
    chk("rst_done", br_done, 0);
    chk("rst_load", pc_load, 0);
    chk("rst_target", pc_target, 0);
    chk("rst_flags", flags_q, 0);
    chk("rst_seen", flg_seen, 0);
    chk("rst_cnt", taken_cnt, 0);
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_ready", br_ready, 1);
  endtask

  vec_t vt[15];
  int pulses;

  initial begin
    // IDLE-path rows: each row is one cycle; flags_q starts at 2'b10, cnt 1, target 0x77.
    vt[0]  = '{1,0,1,0,3'b000,8'h00, 0,0,8'h77,2'b01,8'd1};
    vt[1]  = '{0,0,0,1,3'b001,8'h01, 1,1,8'h01,2'b01,8'd2};
    vt[2]  = '{0,0,0,1,3'b010,8'h02, 1,0,8'h02,2'b01,8'd2};
    vt[3]  = '{0,0,0,1,3'b110,8'h03, 1,1,8'h03,2'b01,8'd3};
    vt[4]  = '{0,0,0,1,3'b011,8'h04, 1,0,8'h04,2'b01,8'd3};
    vt[5]  = '{1,1,0,1,3'b000,8'h05, 1,1,8'h05,2'b10,8'd4};
    vt[6]  = '{0,0,0,1,3'b011,8'h06, 1,1,8'h06,2'b10,8'd5};
    vt[7]  = '{0,0,0,1,3'b100,8'h07, 1,0,8'h07,2'b10,8'd5};
    vt[8]  = '{0,0,0,1,3'b101,8'h08, 1,1,8'h08,2'b10,8'd6};
    vt[9]  = '{1,0,0,1,3'b111,8'h09, 1,0,8'h09,2'b00,8'd6};
    vt[10] = '{0,0,0,1,3'b100,8'h0A, 1,1,8'h0A,2'b00,8'd7};
    vt[11] = '{0,0,0,1,3'b010,8'h0B, 1,1,8'h0B,2'b00,8'd8};
    vt[12] = '{0,0,0,1,3'b001,8'h0C, 1,0,8'h0C,2'b00,8'd8};
    vt[13] = '{1,1,1,0,3'b000,8'h00, 0,0,8'h0C,2'b01,8'd8};
    vt[14] = '{0,0,0,1,3'b110,8'h0D, 1,1,8'h0D,2'b01,8'd9};

    step();
    do_reset();

    // Request with no flags ever seen waits indefinitely.
    br_valid = 1; br_cond = 3'b100; br_target = 8'h55;
    step();
    chk("wait_ready", br_ready, 0);
    chk("wait_done", br_done, 0);
    br_valid = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("wait_hold_ready", br_ready, 0);
      chk("wait_hold_done", br_done, 0);
    end
    flg_valid = 1; flg_gr = 0; flg_e = 0;
    step();
    flg_valid = 0;
    chk("wait_flag_done", br_done, 0);
    chk("wait_flags", flags_q, 2'b00);
    chk("wait_seen", flg_seen, 1);
    step();
    chk("wait_res_done", br_done, 1);
    chk("wait_res_load", pc_load, 1);
    chk("wait_res_tgt", pc_target, 8'h55);
    chk("wait_res_cnt", taken_cnt, 1);
    chk("wait_res_ready", br_ready, 1);

    // Reset while parked in WAIT_FLAGS drops the pending request.
    do_reset();
    br_valid = 1; br_cond = 3'b100; br_target = 8'h66;
    step();
    br_valid = 0;
    step();
    chk("midwait_ready", br_ready, 0);
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step();
      chk("dropped_done", br_done, 0);
      chk("dropped_ready", br_ready, 1);
    end

    // EQ against gr flags: resolved not taken.
    flg_valid = 1; flg_gr = 1; flg_e = 0;
    step();
    flg_valid = 0; br_valid = 1; br_cond = 3'b001; br_target = 8'h3C;
    step();
    br_valid = 0;
    chk("eq_done", br_done, 1);
    chk("eq_load", pc_load, 0);
    chk("eq_tgt", pc_target, 8'h3C);

    // GE against equal flags: taken.
    flg_valid = 1; flg_gr = 0; flg_e = 1;
    step();
    flg_valid = 0; br_valid = 1; br_cond = 3'b101; br_target = 8'h10;
    step();
    br_valid = 0;
    chk("ge_load", pc_load, 1);
    chk("ge_tgt", pc_target, 8'h10);
    chk("ge_cnt", taken_cnt, 1);

    // Flag update and request collide: new flags decide, one extra cycle.
    flg_valid = 1; flg_gr = 1; flg_e = 0;
    br_valid = 1; br_cond = 3'b001; br_target = 8'h77;
    step();
    flg_valid = 0; br_valid = 0;
    chk("col_ready", br_ready, 0);
    chk("col_done_early", br_done, 0);
    chk("col_flags", flags_q, 2'b10);
    step();
    chk("col_done", br_done, 1);
    chk("col_load", pc_load, 0);
    chk("col_tgt", pc_target, 8'h77);
    chk("col_cnt", taken_cnt, 1);
    chk("col_ready_back", br_ready, 1);

    for (int i = 0; i < 15; i++) begin
      flg_valid = vt[i].fv; flg_gr = vt[i].gr; flg_e = vt[i].e;
      br_valid = vt[i].bv; br_cond = vt[i].cond; br_target = vt[i].tgt;
      step();
      chk($sformatf("vec%0d_done", i), br_done, vt[i].x_done);
      chk($sformatf("vec%0d_load", i), pc_load, vt[i].x_load);
      chk($sformatf("vec%0d_tgt", i), pc_target, vt[i].x_tgt);
      chk($sformatf("vec%0d_flags", i), flags_q, vt[i].x_flags);
      chk($sformatf("vec%0d_cnt", i), taken_cnt, vt[i].x_cnt);
      chk($sformatf("vec%0d_ready", i), br_ready, 1);
    end
    flg_valid = 0; br_valid = 0;

    // Illegal flags, then 256 back-to-back ALWAYS branches wrap the counter.
    do_reset();
    flg_valid = 1; flg_gr = 1; flg_e = 1;
    step();
    flg_valid = 0;
    chk("illegal_flags", flags_q, 2'b01);
    pulses = 0;
    br_valid = 1; br_cond = 3'b000;
    for (int i = 0; i < 256; i++) begin
      br_target = 8'(i);
      step();
      if (br_done && pc_load) pulses++;
      if (i == 254) chk("cnt_255", taken_cnt, 8'hFF);
    end
    br_valid = 0;
    chk("b2b_pulses", pulses, 256);
    chk("b2b_cnt_wrap", taken_cnt, 0);
    chk("b2b_tgt", pc_target, 8'hFF);
    step();
    chk("b2b_idle_done", br_done, 0);
    chk("b2b_idle_cnt", taken_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
